// File: rtl/cla_serial_add_ctrl_if.sv
// Operand/result handshake bundle for cla_serial_add_ctrl.
// The slave modport is the adder side; the master modport is the requester/consumer side.
interface cla_serial_add_ctrl_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovfl;
  logic             zero;
  logic             neg;
  logic             busy;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovfl, zero, neg, busy
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovfl, zero, neg, busy
  );
endinterface

// File: rtl/cla_serial_add_ctrl.sv
// Multi-cycle adder: one 4-bit carry-lookahead slice per cycle, LSB nibble first.
// Optional subtract support is enabled by defining CLA_SERIAL_SUB_EN.
module cla_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  cla_serial_add_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  logic [1:0]       state;
  opnd_t            op;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r, ovfl_r, zero_r, neg_r;
  logic             do_sub;

`ifdef CLA_SERIAL_SUB_EN
  assign do_sub = bus.sub;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign do_sub     = 1'b0;
`endif

  // Current slice: generate/propagate and full lookahead off the registered carry
  logic [3:0]       an, bn, p, g, c, sn;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;

  assign an = op.a[{idx, 2'b00} +: 4];
  assign bn = op.b[{idx, 2'b00} +: 4];
  assign p  = an ^ bn;
  assign g  = an & bn;
  assign c[0] = g[0] | (p[0] & carry);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
  assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry);
  assign sn   = p ^ {c[2:0], carry};
  assign last = (idx == IDXW'(NSLICE - 1));

  // Flags must see the nibble being written in the final slice
  always_comb begin
    sum_nxt = sum_r;
    sum_nxt[{idx, 2'b00} +: 4] = sn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op     <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovfl_r <= 1'b0;
      zero_r <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op.a  <= bus.a;
          op.b  <= do_sub ? ~bus.b : bus.b;
          carry <= do_sub | bus.cin;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          sum_r <= sum_nxt;
          carry <= c[3];
          idx   <= idx + IDXW'(1);
          if (last) begin
            cout_r <= c[3];
            ovfl_r <= c[3] ^ c[2];
            zero_r <= (sum_nxt == '0);
            neg_r  <= sum_nxt[WIDTH-1];
            idx    <= '0;
            state  <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ~rst & (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovfl      = ovfl_r;
  assign bus.zero      = zero_r;
  assign bus.neg       = neg_r;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Self-checking bench for cla_serial_add_ctrl (WIDTH=16): vector table, corner sequences,
// and randomized back-to-back traffic against an arithmetic reference model.
module tb_cla_serial_add_ctrl;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;
`ifdef CLA_SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus();
  cla_serial_add_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic; returns {ovfl, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] ra, input logic [15:0] rb,
                                        input logic rci, input logic rsb);
    logic [15:0] bb;
    logic        c;
    logic [16:0] t;
    logic        ov;
    bb = (SUB_EN && rsb) ? ~rb : rb;
    c  = (SUB_EN && rsb) ? 1'b1 : rci;
    t  = {1'b0, ra} + {1'b0, bb} + 17'(c);
    ov = (ra[15] == bb[15]) && (t[15] != ra[15]);
    return {ov, t[16], t[15:0]};
  endfunction

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov, z, n;
  } vec_t;
  vec_t vecs[6];

  // Randomized-phase monitor: scoreboard plus issue-interval check
  logic        mon_en = 1'b0;
  logic [17:0] exp_q[$];
  longint      cyc = 0;
  longint      last_acc = -1;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.in_valid && bus.in_ready) begin
        if (last_acc >= 0) chk("issue_interval_ge6", 32'((cyc - last_acc) >= 6), 32'd1);
        last_acc = cyc;
        exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rand_unexpected_result: got sum %0h with empty scoreboard", bus.sum);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("rand_result", 32'({bus.ovfl, bus.cout, bus.sum}), 32'(e));
        end
      end
    end
  end

  // Issue one request (out_ready as set by caller) and wait until out_valid is visible
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tci,
                        input logic tsb, output int lat);
    int guard;
    @(negedge clk);
    bus.a = ta; bus.b = tb_; bus.cin = tci; bus.sub = tsb; bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin @(negedge clk); guard++; end
    if (guard >= 20) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    if (SUB_EN) begin
      vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    end else begin
      vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0};
    end

    // Reset state
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid_busy", 32'({bus.out_valid, bus.busy}), 32'd0);
    chk("rst_sum_flags", 32'({bus.sum, bus.cout, bus.ovfl, bus.zero, bus.neg}), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(NSLICE));
      chk($sformatf("v%0d_sum", i), 32'(bus.sum), 32'(vecs[i].s));
      chk($sformatf("v%0d_cout_ovfl_zero_neg", i),
          32'({bus.cout, bus.ovfl, bus.zero, bus.neg}),
          32'({vecs[i].co, vecs[i].ov, vecs[i].z, vecs[i].n}));
      @(posedge clk); #1;
      chk($sformatf("v%0d_release", i), 32'({bus.out_valid, bus.in_ready}), 32'b01);
    end

    // Backpressure: result held, new requests ignored
    bus.out_ready = 1'b0;
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    held = 16'h3333;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1; bus.a = 16'($urandom); bus.b = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_hold", 32'({bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.ovfl, bus.zero, bus.neg}),
          32'({1'b1, 1'b0, held, 4'b0000}));
    end
    bus.a = 16'h0100; bus.b = 16'h0001; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    @(posedge clk); #1;
    chk("bp_next_accepted", 32'(bus.busy), 32'd1);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("bp_next_sum", 32'(bus.sum), 32'h0101);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN (idx==2)
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("midrun_partial", 32'({bus.busy, bus.sum[7:0]}), 32'h1FF);
    rst = 1'b1; #1;
    chk("midrun_rst_outputs", 32'({bus.busy, bus.out_valid, bus.in_ready, bus.sum,
                                    bus.cout, bus.ovfl, bus.zero, bus.neg}), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
    chk("post_rst_sum", 32'({bus.cout, bus.sum}), 32'h0002);
    @(posedge clk); #1;

    // Randomized back-to-back traffic with random out_ready
    mon_en = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 1000; n++) begin
      logic acc;
      int   guard;
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      bus.cin = 1'($urandom); bus.sub = 1'($urandom); bus.in_valid = 1'b1;
      acc = 1'b0; guard = 0;
      while (!acc && guard < 200) begin
        bus.out_ready = 1'($urandom);
        @(negedge clk); acc = bus.in_ready;
        @(posedge clk); #1; guard++;
      end
      if (!acc) chk("rand_accept_timeout", 32'(acc), 32'd1);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk); #1;
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
